// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared types, LED bit map and gate evaluator for gate_seq_ctrl
// Purpose: gate and FSM state enums, LED bit positions, gate-evaluate function.
// Ports: none (package).
package gate_seq_pkg;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NAND = 3'd2,
    GATE_NOR  = 3'd3,
    GATE_XOR  = 3'd4,
    GATE_XNOR = 3'd5
  } gate_e;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    HOLD   = 2'd1,
    AUTO   = 2'd2
  } state_e;

  // Last gate index before wrapping back to AND.
  localparam logic [2:0] GATE_LAST = 3'd5;

  // LED bank bit positions (bank is active-low).
  localparam int LED_RES     = 0;
  localparam int LED_OPS_LO  = 1;
  localparam int LED_OPS_HI  = 2;
  localparam int LED_GATE_LO = 3;
  localparam int LED_GATE_HI = 5;

  function automatic logic gate_eval(input logic [2:0] g, input logic a, input logic b);
    logic r;
    case (g)
      GATE_AND:  r = a & b;
      GATE_OR:   r = a | b;
      GATE_NAND: r = ~(a & b);
      GATE_NOR:  r = ~(a | b);
      GATE_XOR:  r = a ^ b;
      GATE_XNOR: r = ~(a ^ b);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_seq_ctrl_btn_debounce.sv
// rtl/gate_seq_ctrl_btn_debounce.sv - synchronizer, debouncer and press pulse for one active-low button
// Purpose: 2-flop synchronizer, stable-level debounce counter, 1-cycle press pulse on stable 1->0.
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   btn_n_i   raw active-low button, asynchronous to clk_i
//   stable_o  debounced level (1 = released)
//   press_o   1-cycle pulse when the debounced level goes 1->0
module btn_debounce #(
  parameter int DB_CYCLES = 540000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic stable_o,
  output logic press_o
);

  localparam int              CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The count tracks consecutive samples that disagree with the stable level;
  // the DB_CYCLES-th such sample flips the level, so the count never exceeds CNT_LAST.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      press_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/gate_seq_ctrl.sv
// rtl/gate_seq_ctrl.sv - front-panel controller for the two-input logic-gate demonstrator
// Purpose: debounces two buttons, selects gate (btn1), steps operands manually or
//          automatically (btn2 short press / long hold), drives the active-low LED bank.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   btn1  raw active-low button: next gate
//   btn2  raw active-low button: step operands / long hold enters AUTO / press leaves AUTO
//   led   registered active-low LEDs: [0]=~r, [2:1]=~{a,b}, [5:3]=~g
module gate_seq_ctrl
  import gate_seq_pkg::*;
#(
  parameter int DB_CYCLES   = 540000,
  parameter int LONG_CYCLES = 27000000,
  parameter int STEP_CYCLES = 13500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn1,
  input  logic       btn2,
  output logic [5:0] led
);

  localparam int            HW        = $clog2(LONG_CYCLES + 1);
  localparam int            SW        = $clog2(STEP_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_DONE = HW'(LONG_CYCLES);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  logic btn1_press, btn1_stable_unused;
  logic btn2_press, btn2_stable;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_btn1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .btn_n_i  (btn1),
    .stable_o (btn1_stable_unused),
    .press_o  (btn1_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_btn2 (
    .clk_i    (clk),
    .rst_i    (rst),
    .btn_n_i  (btn2),
    .stable_o (btn2_stable),
    .press_o  (btn2_press)
  );

  state_e        state_q;
  logic [2:0]    g_q;
  logic [1:0]    ops_q;   // {a,b}
  logic [HW-1:0] hold_q;
  logic [SW-1:0] step_q;
  logic [5:0]    led_q;
  logic          res;

  assign res = gate_eval(g_q, ops_q[1], ops_q[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MANUAL;
      g_q     <= 3'd0;
      ops_q   <= 2'd0;
      hold_q  <= '0;
      step_q  <= '0;
      led_q   <= '1;
    end else begin
      // Gate select is independent of the operand FSM.
      if (btn1_press) begin
        g_q <= (g_q == GATE_LAST) ? 3'd0 : g_q + 3'd1;
      end

      // LEDs show the registered state, so they trail any update by one edge.
      led_q[LED_RES]                 <= ~res;
      led_q[LED_OPS_HI:LED_OPS_LO]   <= ~ops_q;
      led_q[LED_GATE_HI:LED_GATE_LO] <= ~g_q;

      case (state_q)
        MANUAL: begin
          if (btn2_press) begin
            ops_q   <= ops_q + 2'd1;
            hold_q  <= '0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (btn2_stable) begin
            state_q <= MANUAL;
          end else if (hold_q == HOLD_LAST) begin
            // Counter lands on LONG_CYCLES and stays there; no wrap.
            hold_q  <= HOLD_DONE;
            step_q  <= '0;
            state_q <= AUTO;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        AUTO: begin
          // A press takes priority over a coincident step tick.
          if (btn2_press) begin
            step_q  <= '0;
            state_q <= MANUAL;
          end else if (step_q == STEP_LAST) begin
            ops_q  <= ops_q + 2'd1;
            step_q <= '0;
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        default: state_q <= MANUAL;
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// tb/tb_gate_seq_ctrl.sv - directed self-checking bench for gate_seq_ctrl
module tb_gate_seq_ctrl;
  import gate_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       btn1;
  logic       btn2;
  logic [5:0] led;

  int n_checks = 0;
  int n_errors = 0;

  gate_seq_ctrl #(
    .DB_CYCLES   (4),
    .LONG_CYCLES (16),
    .STEP_CYCLES (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .btn1 (btn1),
    .btn2 (btn2),
    .led  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_led(input string tag, input logic [5:0] exp);
    n_checks++;
    assert (led === exp) else begin
      n_errors++;
      $error("FAIL %s: led observed %b expected %b", tag, led, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_e exp);
    n_checks++;
    assert (dut.state_q === exp) else begin
      n_errors++;
      $error("FAIL %s: state observed %0d expected %0d", tag, dut.state_q, exp);
    end
  endtask

  task automatic press_b1(input int hold);
    btn1 = 1'b0;
    cyc(hold);
    btn1 = 1'b1;
    cyc(12);
  endtask

  task automatic press_b2(input int hold);
    btn2 = 1'b0;
    cyc(hold);
    btn2 = 1'b1;
    cyc(12);
  endtask

  initial begin
    // Reset with buttons held down: synchronizers must still read released.
    rst  = 1'b1;
    btn1 = 1'b0;
    btn2 = 1'b0;
    cyc(3);
    chk_led("reset_hold", 6'b111111);
    rst  = 1'b0;
    btn1 = 1'b1;
    btn2 = 1'b1;
    cyc(10);
    chk_led("after_reset", 6'b111111);
    chk_state("after_reset_state", MANUAL);

    // 3-cycle glitch: below DB_CYCLES, no event.
    btn1 = 1'b0;
    cyc(3);
    btn1 = 1'b1;
    cyc(12);
    chk_led("glitch", 6'b111111);

    // 10-cycle press: pulse after 2+4 edges, g at 7th, led at 8th.
    btn1 = 1'b0;
    cyc(7);
    chk_led("latency_n7", 6'b111111);
    cyc(1);
    chk_led("latency_n8", 6'b110111);
    cyc(2);
    btn1 = 1'b1;
    cyc(12);
    chk_led("one_step_or", 6'b110111);

    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    chk_led("reset2", 6'b111111);

    // Manual operand stepping under AND.
    press_b2(8);
    chk_led("man_01", 6'b111101);
    chk_state("man_01_state", MANUAL);
    press_b2(8);
    chk_led("man_10", 6'b111011);
    chk_state("man_10_state", MANUAL);
    press_b2(8);
    chk_led("man_11", 6'b111000);
    chk_state("man_11_state", MANUAL);
    press_b2(8);
    chk_led("man_00", 6'b111111);
    chk_state("man_00_state", MANUAL);
    press_b2(8);
    press_b2(8);
    press_b2(8);
    chk_led("man_to_11", 6'b111000);

    // Gate sweep with {a,b}=11.
    press_b1(8);
    chk_led("sweep_or", 6'b110000);
    press_b1(8);
    chk_led("sweep_nand", 6'b101001);
    press_b1(8);
    chk_led("sweep_nor", 6'b100001);
    press_b1(8);
    chk_led("sweep_xor", 6'b011001);
    press_b1(8);
    chk_led("sweep_xnor", 6'b010000);
    press_b1(8);
    chk_led("sweep_wrap_and", 6'b111000);

    // Auto: press at N0, step at E7, AUTO at E23, ticks at E31/E39/E47/E55.
    btn2 = 1'b0;
    cyc(22);
    chk_state("auto_hold_n22", HOLD);
    cyc(1);
    chk_state("auto_enter_n23", AUTO);
    cyc(7);
    chk_led("auto_press_step", 6'b111111);
    btn2 = 1'b1;
    cyc(2);
    chk_led("auto_tick1", 6'b111101);
    cyc(8);
    chk_led("auto_tick2", 6'b111011);
    cyc(8);
    chk_led("auto_tick3", 6'b111000);
    btn2 = 1'b0;
    cyc(6);
    chk_state("auto_before_exit", AUTO);
    cyc(1);
    chk_state("auto_exit", MANUAL);
    cyc(1);
    chk_led("auto_exit_no_step", 6'b111000);
    btn2 = 1'b1;
    cyc(30);
    chk_led("auto_frozen", 6'b111000);
    chk_state("auto_frozen_state", MANUAL);

    // Simultaneous presses: g 0->1, {a,b} 11->00.
    btn1 = 1'b0;
    btn2 = 1'b0;
    cyc(8);
    btn1 = 1'b1;
    btn2 = 1'b1;
    cyc(14);
    chk_led("simultaneous", 6'b110111);
    chk_state("simultaneous_state", MANUAL);

    // Reset while in AUTO.
    btn2 = 1'b0;
    cyc(30);
    chk_state("pre_reset_auto", AUTO);
    chk_led("pre_reset_led", 6'b110100);
    rst  = 1'b1;
    btn2 = 1'b1;
    cyc(1);
    chk_led("reset_in_auto", 6'b111111);
    cyc(1);
    rst = 1'b0;
    cyc(30);
    chk_led("post_reset_idle", 6'b111111);
    chk_state("post_reset_state", MANUAL);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gate_seq_ctrl.md
# gate_seq_ctrl

Front-panel controller for the board's two-input logic-gate demonstrator. Debounces the two active-low push buttons and sequences the shared gate evaluator through six gate functions and four operand combinations, either stepped by hand or auto-stepped. The active-low 6-LED bank shows the result, the operands and the selected gate. It sits between the board pins and the LEDs as the top-level user-interface block.

## Interface
- DB_CYCLES, 540000: consecutive stable samples before a button level is accepted (20 ms at 27 MHz); ≥1
- LONG_CYCLES, 27000000: btn2 hold time that enters AUTO (1 s); ≥1
- STEP_CYCLES, 13500000: AUTO operand step period (0.5 s); ≥1
- clk  input  1  system clock; one clock domain
- rst  input  1  reset, synchronous, active-high
- btn1  input  1  raw button, active-low (0 = pressed), asynchronous to clk
- btn2  input  1  raw button, active-low, asynchronous to clk
- led  output  6  registered, active-low (0 = lit)

## Operation
- Each button: 2-flop synchronizer, then debouncer. The stable level changes only after DB_CYCLES consecutive synchronized samples differ from it. Any sample equal to the stable level restarts the count. Press event = 1-cycle pulse when the stable level goes 1→0. Release produces no event.
- Gate index g, 3 bits: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR. A btn1 press sets g to g+1, and 5 wraps to 0. This works in every state and never touches mode, operands or timers.
- Operands {a,b}, 2-bit counter: 00→01→10→11→00.
- Result r = gate_g(a,b).
- LED map, each bit the inverse of its value: led[0]=~r, led[2:1]=~{a,b}, led[5:3]=~g.
- FSM states: MANUAL, HOLD, AUTO.
  - MANUAL, btn2 press: step operands, go to HOLD, clear hold counter.
  - HOLD, btn2 stable still pressed: hold counter increments each cycle. When it reaches LONG_CYCLES: go to AUTO, clear step timer, no operand step.
  - HOLD, btn2 stable released before LONG_CYCLES: go to MANUAL.
  - AUTO: step timer counts. At STEP_CYCLES it steps the operands and restarts from 0.
  - AUTO, btn2 press: go to MANUAL with no step. The later release does nothing.
- Counter widths are $clog2(max+1). No counter ever wraps past its terminal value.

## Timing
- Reset (rst=1 at a clk edge) sets:
  - g=0, {a,b}=00, state MANUAL, all counters 0
  - debouncer stable levels = 1 (released), synchronizer flops = 1
  - led=6'b111111
- Reset mid-operation (any state, any count) aborts immediately, with no residual events.
- Latency from a raw pin transition to the press pulse: 2 sync cycles plus DB_CYCLES.
- The press pulse updates g, {a,b} or state at the next edge. led reflects the new state one edge later.
- btn1 and btn2 presses in the same cycle: both take effect in that cycle, independently.
- AUTO step tick and btn2 press in the same cycle: exit wins, no step.
- A glitch shorter than DB_CYCLES samples produces no event and no state change.
- Only one event per press, however long the button is held.

## Structure
- gate_seq_pkg holds:
  - gate enum (6 values)
  - FSM state enum (MANUAL/HOLD/AUTO)
  - LED bit-position constants (RES=0, OPS=2:1, GATE=5:3)
  - gate-evaluate function
- Sub-module btn_debounce (synchronizer, debounce counter, press pulse) is instantiated once per button, parameterized by DB_CYCLES.

## Test plan
Bench parameters: DB_CYCLES=4, LONG_CYCLES=16, STEP_CYCLES=8.
- Reset: hold rst 3 cycles with btn1=btn2=0 → led=111111; after release with buttons up, led stays 111111 (AND, 00, r=0).
- Debounce: 3-cycle low glitch on btn1 → no change. Low for 10 cycles → exactly one g step, led[5:3]=110 (g=1, OR).
- Gate sweep: 6 btn1 presses from reset with {a,b}=11 → r sequence 1,1,0,0,0,1. After the 6th press g=0 again (wrap).
- Manual step: 4 short btn2 presses (each held 8 cycles) → {a,b}=01,10,11,00. State returns to MANUAL each time.
- Auto: hold btn2 30 cycles → one step at the press, AUTO after 16 stable-held cycles, then a step every 8 cycles. A btn2 press coinciding with a tick → MANUAL, no step. Operands then freeze.
- Simultaneous and reset: btn1 and btn2 pressed in the same cycle → g and {a,b} both advance. Assert rst while in AUTO → all values return to reset and no step occurs afterwards.
